// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
//
// Contents:
//   MEM_ADDR_LEN - default width of the core byte address and RAM halfword index
//   SIZE_*       - request size encodings (SIZE_RSVD is the reserved code 2'b11)
//   mau_state_t  - access sequencer state encoding
package mem_access_unit_pkg;

    localparam int MEM_ADDR_LEN = 32;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_LO  = 3'd1,
        RD_HI  = 3'd2,
        RD_FIN = 3'd3,
        WR_LO  = 3'd4,
        WR_HI  = 3'd5,
        RMW_WR = 3'd6,
        RESP   = 3'd7
    } mau_state_t;

endpackage

// File: rtl/mem_load_align.sv
// Load result alignment and extension (purely combinational).
//
// Ports:
//   lo          - halfword holding the addressed byte/half, or bits [15:0] of a word
//   hi          - bits [31:16] of a word (ignored for byte/half)
//   size        - SIZE_BYTE / SIZE_HALF; anything else returns {hi, lo}
//   lane        - byte lane within lo (0 = [7:0], 1 = [15:8])
//   is_unsigned - 1 = zero-extend, 0 = sign-extend
//   result      - 32-bit extended load value
module mem_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [15:0] lo,
    input  logic [15:0] hi,
    input  logic [1:0]  size,
    input  logic        lane,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0] lane_bytes [2];
    logic [7:0] byte_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_bytes[gi] = lo[gi*8 +: 8];
        end
    endgenerate

    assign byte_sel = lane_bytes[lane];

    always_comb begin
        result = {hi, lo};
        case (size)
            SIZE_BYTE: result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SIZE_HALF: result = {{16{~is_unsigned & lo[15]}}, lo};
            default:   result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Core-side load/store initiator for a 16-bit single-port RAM.
//
// Splits one byte/half/word request into one or two halfword RAM accesses.
// Byte stores are done as read-modify-write; loads are sign/zero-extended.
//
// Ports:
//   clk, rst                      - clock; synchronous active-high reset
//   req_valid/req_ready           - request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned, req_addr, req_wdata - request fields
//   resp_valid                    - one-cycle completion pulse
//   resp_rdata                    - last load result (held across stores)
//   resp_err                      - misaligned / reserved size, with resp_valid
//   ram_we, ram_addr, ram_wdata   - RAM command (halfword index)
//   ram_rdata                     - RAM read data, one cycle after the address
//
// Build option: define MEM_ACCESS_MISALIGN_CHECK_EN to reject misaligned
// half/word requests and the reserved size with resp_err. Without it the
// low address bits are ignored, size 2'b11 behaves as a word, and resp_err
// is always 0.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_LEN = MEM_ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [31:0]         req_wdata,
    output logic                resp_valid,
    output logic [31:0]         resp_rdata,
    output logic                resp_err,
    output logic                ram_we,
    output logic [ADDR_LEN-1:0] ram_addr,
    output logic [15:0]         ram_wdata,
    input  logic [15:0]         ram_rdata
);

    mau_state_t          state_reg;
    mau_state_t          state_next;

    logic                we_reg;
    logic [1:0]          size_reg;
    logic                unsigned_reg;
    logic                lane_reg;
    logic [ADDR_LEN-1:0] haddr_reg;
    logic [31:0]         wdata_reg;
    logic [15:0]         lo_reg;
    logic [31:0]         rdata_reg;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    logic                err_reg;
    logic                req_bad;
`endif

    logic                accept;
    logic [1:0]          size_eff;
    logic [ADDR_LEN-1:0] haddr_eff;
    logic [ADDR_LEN-1:0] haddr_inc;
    logic [15:0]         rmw_data;
    logic [15:0]         align_lo;
    logic [31:0]         load_result;
    logic                ram_we_c;

    assign req_ready = (state_reg == IDLE);
    assign accept    = req_valid && req_ready;
    // Second halfword of a word; wraps naturally at ADDR_LEN bits.
    assign haddr_inc = haddr_reg + ADDR_LEN'(1);

    // Request decode at accept time: normalise size and halfword index.
    always_comb begin
        size_eff  = req_size;
        haddr_eff = req_addr >> 1;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        req_bad = (req_size == SIZE_RSVD)
               || ((req_size == SIZE_HALF) && req_addr[0])
               || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
        if (req_size == SIZE_RSVD) begin
            size_eff = SIZE_WORD;
        end
        // Word accesses ignore addr[1]; halves already drop addr[0] via the shift.
        if (size_eff == SIZE_WORD) begin
            haddr_eff[0] = 1'b0;
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    // Byte stores start with a read for the merge.
                    if (req_we && (size_eff != SIZE_BYTE)) begin
                        state_next = WR_LO;
                    end else begin
                        state_next = RD_LO;
                    end
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
                    if (req_bad) begin
                        state_next = RESP;
                    end
`endif
                end
            end
            RD_LO: begin
                if (we_reg) begin
                    state_next = RMW_WR;
                end else if (size_reg == SIZE_WORD) begin
                    state_next = RD_HI;
                end else begin
                    state_next = RD_FIN;
                end
            end
            RD_HI:  state_next = RD_FIN;
            RD_FIN: state_next = RESP;
            WR_LO:  state_next = (size_reg == SIZE_WORD) ? WR_HI : RESP;
            WR_HI:  state_next = RESP;
            RMW_WR: state_next = RESP;
            RESP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Byte-store merge: replace the addressed lane of the halfword just read.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rmw_lane
            assign rmw_data[gi*8 +: 8] = (lane_reg == 1'(gi)) ? wdata_reg[7:0]
                                                             : ram_rdata[gi*8 +: 8];
        end
    endgenerate

    // RAM command decode from state and captured request.
    always_comb begin
        ram_we_c  = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_reg)
            RD_LO: ram_addr = haddr_reg;
            RD_HI: ram_addr = haddr_inc;
            WR_LO: begin
                ram_we_c  = 1'b1;
                ram_addr  = haddr_reg;
                ram_wdata = wdata_reg[15:0];
            end
            WR_HI: begin
                ram_we_c  = 1'b1;
                ram_addr  = haddr_inc;
                ram_wdata = wdata_reg[31:16];
            end
            RMW_WR: begin
                ram_we_c  = 1'b1;
                ram_addr  = haddr_reg;
                ram_wdata = rmw_data;
            end
            default: ;
        endcase
    end

    // Reset takes effect only at the next edge; block writes immediately.
    assign ram_we = ram_we_c && !rst;

    // In RD_FIN a word combines the latched low half with the live high half;
    // byte/half use the single halfword just returned.
    assign align_lo = (size_reg == SIZE_WORD) ? lo_reg : ram_rdata;

    mem_load_align u_load_align (
        .lo          (align_lo),
        .hi          (ram_rdata),
        .size        (size_reg),
        .lane        (lane_reg),
        .is_unsigned (unsigned_reg),
        .result      (load_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            size_reg     <= SIZE_BYTE;
            unsigned_reg <= 1'b0;
            lane_reg     <= 1'b0;
            haddr_reg    <= '0;
            wdata_reg    <= '0;
            lo_reg       <= '0;
            rdata_reg    <= '0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
            err_reg      <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg       <= req_we;
                size_reg     <= size_eff;
                unsigned_reg <= req_unsigned;
                lane_reg     <= req_addr[0];
                haddr_reg    <= haddr_eff;
                wdata_reg    <= req_wdata;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
                err_reg      <= req_bad;
`endif
            end
            if (state_reg == RD_HI) begin
                lo_reg <= ram_rdata;
            end
            if (state_reg == RD_FIN) begin
                rdata_reg <= load_result;
            end
        end
    end

    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = rdata_reg;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    assign resp_err   = (state_reg == RESP) && err_reg;
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// requests compared against a byte-addressed reference memory model.
// Honours MEM_ACCESS_MISALIGN_CHECK_EN the same way as the design.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // RAM behavioural model (registered read) with a backdoor write port.
    logic [15:0] ram_mem [256];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = '0;
    logic [15:0] bd_data = '0;

    // Reference: byte-addressed, little-endian; halfword i = bytes 2i, 2i+1.
    logic [7:0]  ref_mem [512];
    logic [31:0] exp_rdata = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) ram_mem[bd_addr] <= bd_data;
        else if (ram_we) ram_mem[ram_addr[7:0]] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr[7:0]];
    end

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_half(input int idx);
        return {ref_mem[(2*idx+1) & 511], ref_mem[(2*idx) & 511]};
    endfunction

    // Backdoor write, kept coherent with the reference. Returns at a negedge.
    task automatic bd_write(input int idx, input logic [15:0] data);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = 8'(idx); bd_data = data;
        @(posedge clk);
        #1 bd_we = 1'b0;
        ref_mem[(2*idx) & 511]   = data[7:0];
        ref_mem[(2*idx+1) & 511] = data[15:8];
        @(negedge clk);
    endtask

    // Reference model: updates ref_mem / exp_rdata and returns the expected
    // latency (cycles from accept to resp_valid), write count and error.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output int nwr, output logic err,
                         output logic [31:0] eff);
        int nbytes;
        logic [31:0] v;
        err = 1'b0;
        eff = addr;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        if (size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)) begin
            err = 1'b1; lat = 1; nwr = 0;
            return;
        end
`endif
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        if (nbytes == 2) eff[0] = 1'b0;
        if (nbytes == 4) eff[1:0] = 2'b00;
        if (we) begin
            for (int i = 0; i < nbytes; i++)
                ref_mem[int'((eff + 32'(i)) & 32'h1FF)] = wdata[8*i +: 8];
            lat = (nbytes == 2) ? 2 : 3;
            nwr = (nbytes == 4) ? 2 : 1;
        end else begin
            v = '0;
            for (int i = 0; i < nbytes; i++)
                v[8*i +: 8] = ref_mem[int'((eff + 32'(i)) & 32'h1FF)];
            if (!uns && nbytes == 1 && v[7])  v[31:8]  = '1;
            if (!uns && nbytes == 2 && v[15]) v[31:16] = '1;
            exp_rdata = v;
            lat = (nbytes == 4) ? 4 : 3;
            nwr = 0;
        end
    endtask

    // One request; call and return at a negedge. hold keeps req_valid high.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
        int lat, nwr, got_lat, we_cnt, act, rdy_hi, w;
        logic err;
        logic [31:0] eff;
        logic got_err;
        model(we, size, uns, addr, wdata, lat, nwr, err, eff);
        req_valid = 1'b1; req_we = we; req_size = size;
        req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_wait", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 if (!hold) req_valid = 1'b0;
        got_lat = 0; we_cnt = 0; act = 0; rdy_hi = 0; got_err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                got_lat = k;
                got_err = resp_err;
                check("rdata", resp_rdata, exp_rdata);
                break;
            end
            if (ram_we) we_cnt++;
            if (ram_we || ram_addr != 0) act++;
            if (req_ready) rdy_hi++;
        end
        check("latency", 32'(got_lat), 32'(lat));
        check("resp_err", 32'(got_err), 32'(err));
        check("writes", 32'(we_cnt), 32'(nwr));
        check("ready_busy", 32'(rdy_hi), 32'd0);
        if (err) check("no_ram", 32'(act), 32'd0);
        @(negedge clk);
        check("pulse", 32'(resp_valid), 32'd0);
        if (we && !err) begin
            check("ram_h0", 32'(ram_mem[eff[8:1]]), 32'(ref_half(int'(eff[8:1]))));
            check("ram_h1", 32'(ram_mem[eff[8:1] + 8'd1]), 32'(ref_half(int'(eff[8:1]) + 1)));
        end
        $display("txn %0d we=%0d size=%0d uns=%0d addr=%h wdata=%h lat=%0d err=%0d rdata=%h",
                 txn, we, size, uns, addr, wdata, got_lat, got_err, resp_rdata);
        txn++;
    endtask

    initial begin
        int mism;
        logic [15:0] p1;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) bd_write(i, 16'($urandom));
        check("rst_ram_we_forced", 32'(ram_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);

        // Word store then load.
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        check("sw_ram8", 32'(ram_mem[8]), 32'h0000BEEF);
        check("sw_ram9", 32'(ram_mem[9]), 32'h0000DEAD);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        check("lw_value", resp_rdata, 32'hDEADBEEF);

        // Byte/half extension.
        bd_write(3, 16'h80F0);
        do_req(1'b0, 2'd0, 1'b0, 32'h7, 32'h0, 1'b0);
        check("lb_signed", resp_rdata, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h6, 32'h0, 1'b0);
        check("lbu", resp_rdata, 32'h000000F0);
        do_req(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, 1'b0);
        check("lh_signed", resp_rdata, 32'hFFFF80F0);

        // Byte store read-modify-write.
        bd_write(3, 16'h1234);
        do_req(1'b1, 2'd0, 1'b0, 32'h7, 32'h000000AB, 1'b0);
        check("sb_rmw", 32'(ram_mem[3]), 32'h0000AB34);

        // Three stores with req_valid held high.
        do_req(1'b1, 2'd1, 1'b0, 32'h20, 32'h00001111, 1'b1);
        do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h00000022, 1'b1);
        do_req(1'b1, 2'd2, 1'b0, 32'h24, 32'h33334444, 1'b0);
        check("b2b_ram10", 32'(ram_mem[16]), 32'h00002211);
        check("b2b_ram12", 32'(ram_mem[18]), 32'h00004444);
        check("b2b_ram13", 32'(ram_mem[19]), 32'h00003333);

        // Reset during the WR_HI cycle of a word store.
        p1 = ram_mem[33];
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h40; req_wdata = 32'h11223344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_we", 32'(ram_we), 32'd0);
        check("rst_mid_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        ref_mem[32'h40] = 8'h44; ref_mem[32'h41] = 8'h33;
        exp_rdata = '0;
        mism = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) mism++;
        end
        check("rst_mid_noresp", 32'(mism), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        check("rst_mid_lo", 32'(ram_mem[32]), 32'h00003344);
        check("rst_mid_hi", 32'(ram_mem[33]), 32'(p1));

        // Misaligned word load (error with the check enabled, else reads RAM[0..1]).
        do_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 511));
            do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
                   1'($urandom_range(0, 3) == 0));
        end
        req_valid = 1'b0;
        @(negedge clk);

        mism = 0;
        for (int i = 0; i < 256; i++)
            if (ram_mem[i] !== ref_half(i)) mism++;
        check("ram_image", 32'(mism), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
